// File: rtl/lambda_lexer.sv
// lambda_lexer: tokenizer for lambda-calculus source text.
// Takes 9-bit chars (9'h1ff = EOF, otherwise bits[7:0] ASCII), drops
// whitespace and hands one registered token per valid/ready handshake to the
// parser. It also reports progress on a general::status_t port.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_char/in_valid     char stream in; in_ready = lexer accepts this cycle
//   tok_valid/tok_ready  token handshake out
//   tok_type             0 LAMBDA, 1 DOT, 2 LPAREN, 3 RPAREN, 4 IDENT, 5 EOF, 6 ERR
//   tok_text/tok_len     IDENT chars (first char in [7:0], unused bytes 0), length
//   tok_pos              index of the token's first char (ERR: offending char)
//   status               ok / busy / eof / err
//
// Build option: define LEX_COMMENT_EN to enable '#'-to-end-of-line comments.
// When it is undefined, '#' is an illegal char.

package general;
  typedef enum logic [2:0] {
    status_ok   = 3'd0,
    status_busy = 3'd1,
    status_eof  = 3'd2,
    status_err  = 3'd3
  } status_t;
endpackage

module lambda_lexer #(
  parameter int MAX_IDENT = 8,
  parameter int POS_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [8:0]                     in_char,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           tok_valid,
  input  logic                           tok_ready,
  output logic [2:0]                     tok_type,
  output logic [8*MAX_IDENT-1:0]         tok_text,
  output logic [$clog2(MAX_IDENT+1)-1:0] tok_len,
  output logic [POS_W-1:0]               tok_pos,
  output general::status_t               status
);

  localparam int LW = $clog2(MAX_IDENT+1);

  localparam logic [2:0] S_SCAN    = 3'd0;
  localparam logic [2:0] S_IDENT   = 3'd1;
  localparam logic [2:0] S_HELD    = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;
  localparam logic [2:0] S_COMMENT = 3'd5;

  localparam logic [2:0] T_LAMBDA = 3'd0;
  localparam logic [2:0] T_DOT    = 3'd1;
  localparam logic [2:0] T_LPAREN = 3'd2;
  localparam logic [2:0] T_RPAREN = 3'd3;
  localparam logic [2:0] T_IDENT  = 3'd4;
  localparam logic [2:0] T_EOF    = 3'd5;
  localparam logic [2:0] T_ERR    = 3'd6;

  localparam logic [8:0] EOF_CHAR = 9'h1ff;

  function automatic logic is_lower(input logic [8:0] c);
    return !c[8] && (c[7:0] >= 8'h61) && (c[7:0] <= 8'h7a);
  endfunction

  function automatic logic is_identc(input logic [8:0] c);
    return is_lower(c) || c == 9'h05f ||
           (!c[8] && (c[7:0] >= 8'h30) && (c[7:0] <= 8'h39));
  endfunction

  logic [2:0]             state, state_n;
  logic [POS_W-1:0]       pos_cnt, pos_n;
  logic [8*MAX_IDENT-1:0] ident_buf, ident_buf_n;
  logic [LW-1:0]          ident_len, ident_len_n;
  logic [POS_W-1:0]       ident_pos, ident_pos_n;
  logic [8:0]             held_char, held_char_n;
  logic [POS_W-1:0]       held_pos, held_pos_n;
  logic                   tok_valid_n;
  logic [2:0]             tok_type_n;
  logic [8*MAX_IDENT-1:0] tok_text_n;
  logic [LW-1:0]          tok_len_n;
  logic [POS_W-1:0]       tok_pos_n;

  logic                   can_emit, accept;
  logic                   scan_go;
  logic [8:0]             scan_char;
  logic [POS_W-1:0]       scan_pos;
  logic                   emit;
  logic [2:0]             emit_type;
  logic [8*MAX_IDENT-1:0] emit_text;
  logic [LW-1:0]          emit_len;
  logic [POS_W-1:0]       emit_pos;

  // The output register is free when empty or being retired this cycle.
  assign can_emit = !tok_valid || tok_ready;
  assign in_ready = (state == S_SCAN || state == S_IDENT || state == S_COMMENT) && can_emit;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n     = state;
    pos_n       = pos_cnt;
    ident_buf_n = ident_buf;
    ident_len_n = ident_len;
    ident_pos_n = ident_pos;
    held_char_n = held_char;
    held_pos_n  = held_pos;
    tok_valid_n = tok_valid && !tok_ready;
    tok_type_n  = tok_type;
    tok_text_n  = tok_text;
    tok_len_n   = tok_len;
    tok_pos_n   = tok_pos;
    scan_go     = 1'b0;
    scan_char   = '0;
    scan_pos    = '0;
    emit        = 1'b0;
    emit_type   = T_ERR;
    emit_text   = '0;
    emit_len    = '0;
    emit_pos    = '0;

    if (accept) pos_n = pos_cnt + 1'b1;

    // SCAN and HELD share one char classifier; HELD feeds it the stored
    // delimiter and its stored position instead of the input port.
    case (state)
      S_SCAN: if (accept) begin
        scan_go   = 1'b1;
        scan_char = in_char;
        scan_pos  = pos_cnt;
      end
      S_HELD: if (can_emit) begin
        scan_go   = 1'b1;
        scan_char = held_char;
        scan_pos  = held_pos;
      end
      S_IDENT: if (accept) begin
        if (is_identc(in_char)) begin
          if (ident_len == LW'(MAX_IDENT)) begin
            emit     = 1'b1;
            emit_pos = pos_cnt;
            state_n  = S_ERROR;
          end else begin
            ident_buf_n[ident_len*8 +: 8] = in_char[7:0];
            ident_len_n = ident_len + 1'b1;
          end
        end else begin
          emit        = 1'b1;
          emit_type   = T_IDENT;
          emit_text   = ident_buf;
          emit_len    = ident_len;
          emit_pos    = ident_pos;
          held_char_n = in_char;
          held_pos_n  = pos_cnt;
          state_n     = S_HELD;
        end
      end
`ifdef LEX_COMMENT_EN
      S_COMMENT: if (accept) begin
        if (in_char == EOF_CHAR) begin
          emit      = 1'b1;
          emit_type = T_EOF;
          emit_pos  = pos_cnt;
          state_n   = S_DONE;
        end else if (in_char == 9'h00a) begin
          state_n = S_SCAN;
        end
      end
`endif
      default: ;
    endcase

    if (scan_go) begin
      state_n  = S_SCAN;
      emit_pos = scan_pos;
      case (scan_char)
        9'h020, 9'h009, 9'h00a, 9'h00d: ;
        9'h05c: begin emit = 1'b1; emit_type = T_LAMBDA; end
        9'h02e: begin emit = 1'b1; emit_type = T_DOT;    end
        9'h028: begin emit = 1'b1; emit_type = T_LPAREN; end
        9'h029: begin emit = 1'b1; emit_type = T_RPAREN; end
        EOF_CHAR: begin
          emit      = 1'b1;
          emit_type = T_EOF;
          state_n   = S_DONE;
        end
`ifdef LEX_COMMENT_EN
        9'h023: state_n = S_COMMENT;
`endif
        default: begin
          if (is_lower(scan_char)) begin
            ident_buf_n        = '0;
            ident_buf_n[7:0]   = scan_char[7:0];
            ident_len_n        = LW'(1);
            ident_pos_n        = scan_pos;
            state_n            = S_IDENT;
          end else begin
            emit    = 1'b1;
            state_n = S_ERROR;
          end
        end
      endcase
    end

    if (emit) begin
      tok_valid_n = 1'b1;
      tok_type_n  = emit_type;
      tok_text_n  = emit_text;
      tok_len_n   = emit_len;
      tok_pos_n   = emit_pos;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_SCAN;
      pos_cnt   <= '0;
      ident_buf <= '0;
      ident_len <= '0;
      ident_pos <= '0;
      held_char <= '0;
      held_pos  <= '0;
      tok_valid <= 1'b0;
      tok_type  <= '0;
      tok_text  <= '0;
      tok_len   <= '0;
      tok_pos   <= '0;
    end else begin
      state     <= state_n;
      pos_cnt   <= pos_n;
      ident_buf <= ident_buf_n;
      ident_len <= ident_len_n;
      ident_pos <= ident_pos_n;
      held_char <= held_char_n;
      held_pos  <= held_pos_n;
      tok_valid <= tok_valid_n;
      tok_type  <= tok_type_n;
      tok_text  <= tok_text_n;
      tok_len   <= tok_len_n;
      tok_pos   <= tok_pos_n;
    end
  end

  always_comb begin
    if (tok_valid || state == S_IDENT || state == S_HELD) status = general::status_busy;
    else if (state == S_DONE)                              status = general::status_eof;
    else if (state == S_ERROR)                             status = general::status_err;
    else                                                   status = general::status_ok;
  end

endmodule
